// File: rtl/multi_op_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multi_op_sequencer_pkg
// Description : Shared FSM encoding, default parameters and width helper for
//               the multi-operation Booth sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package multi_op_sequencer_pkg;

    localparam int C_DATA_WIDTH     = 8;
    localparam int C_FIFO_DEPTH     = 2;
    localparam int C_TIMEOUT_CYCLES = 64;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Index width that never collapses to zero bits for tiny ranges.
    function automatic int f_index_width(input int range_n);
        return (range_n < 2) ? 1 : $clog2(range_n);
    endfunction

endpackage : multi_op_sequencer_pkg
`default_nettype wire

// File: rtl/multi_op_fifo.sv
`default_nettype none
// ============================================================================
// Module      : multi_op_fifo
// Description : Operand-pair buffer with push/pop and full/empty flags.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_op_fifo
    import multi_op_sequencer_pkg::*;
#(
    parameter int DATA_W = 2 * C_DATA_WIDTH,
    parameter int DEPTH  = C_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int c_ptr_w = f_index_width(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH) + 1;
    localparam logic [c_cnt_w-1:0] c_full_count = c_cnt_w'(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    // Full blocks a push even when a pop happens in the same cycle.
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == c_full_count);
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : multi_op_fifo
`default_nettype wire

// File: rtl/multi_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : multi_op_sequencer
// Description : Buffers signed operand pairs and sequences them one at a time
//               through an external Booth multiplier core. Optional watchdog
//               enabled by macro MULTI_SEQ_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_op_sequencer
    import multi_op_sequencer_pkg::*;
#(
    parameter int Data_Width     = C_DATA_WIDTH,
    parameter int Fifo_Depth     = C_FIFO_DEPTH,
    parameter int Timeout_Cycles = C_TIMEOUT_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    In_Valid,
    output logic                    In_Ready,
    input  logic [Data_Width-1:0]   In_Multiplicand,
    input  logic [Data_Width-1:0]   In_Multiplier,
    output logic                    Multi_En,
    output logic [Data_Width-1:0]   Multiplicand,
    output logic [Data_Width-1:0]   Multiplier,
    input  logic                    Multip_Finsh,
    input  logic [2*Data_Width-1:0] Multiplication_Out,
    output logic                    Out_Valid,
    input  logic                    Out_Ready,
    output logic [2*Data_Width-1:0] Out_Product,
    output logic                    Out_Error
);

    if ((Fifo_Depth < 2) || ((Fifo_Depth & (Fifo_Depth - 1)) != 0) ||
        (Timeout_Cycles < 2)) begin : g_param_check
        $fatal(1, "multi_op_sequencer: unsupported Fifo_Depth or Timeout_Cycles");
    end

    logic [1:0]              r_state;
    logic                    r_multi_en;
    logic [Data_Width-1:0]   r_multiplicand;
    logic [Data_Width-1:0]   r_multiplier;
    logic                    r_out_valid;
    logic [2*Data_Width-1:0] r_out_product;

    logic                    w_full;
    logic                    w_empty;
    logic [2*Data_Width-1:0] w_head;
    logic                    w_finish;
    logic                    w_timeout;
    logic                    w_pop;

    multi_op_fifo #(
        .DATA_W (2 * Data_Width),
        .DEPTH  (Fifo_Depth)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (In_Valid),
        .i_pop   (w_pop),
        .i_data  ({In_Multiplicand, In_Multiplier}),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign In_Ready     = !w_full;
    assign Multi_En     = r_multi_en;
    assign Multiplicand = r_multiplicand;
    assign Multiplier   = r_multiplier;
    assign Out_Valid    = r_out_valid;
    assign Out_Product  = r_out_product;

    // Completion from the core only matters while an operation is running.
    assign w_finish = (r_state == ST_RUN) && Multip_Finsh;
    assign w_pop    = w_finish || w_timeout;

`ifdef MULTI_SEQ_TIMEOUT_EN
    localparam int c_wd_w = f_index_width(Timeout_Cycles);
    localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(Timeout_Cycles - 1);

    logic [c_wd_w-1:0] r_watchdog;
    logic              r_out_error;

    assign w_timeout = (r_state == ST_RUN) && !Multip_Finsh && (r_watchdog == c_wd_last);
    assign Out_Error = r_out_error;

    // Held at zero outside RUN so every operation starts counting from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_watchdog <= '0;
        end else if (r_state == ST_RUN) begin
            r_watchdog <= r_watchdog + 1'b1;
        end else begin
            r_watchdog <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_error <= 1'b0;
        end else if (w_finish) begin
            r_out_error <= 1'b0;
        end else if (w_timeout) begin
            r_out_error <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign Out_Error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_multi_en     <= 1'b0;
            r_multiplicand <= '0;
            r_multiplier   <= '0;
            r_out_valid    <= 1'b0;
            r_out_product  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_state        <= ST_RUN;
                        r_multi_en     <= 1'b1;
                        r_multiplicand <= w_head[2*Data_Width-1:Data_Width];
                        r_multiplier   <= w_head[Data_Width-1:0];
                    end
                end
                ST_RUN: begin
                    if (w_finish) begin
                        r_state       <= ST_DONE;
                        r_multi_en    <= 1'b0;
                        r_out_valid   <= 1'b1;
                        r_out_product <= Multiplication_Out;
                    end else if (w_timeout) begin
                        r_state       <= ST_DONE;
                        r_multi_en    <= 1'b0;
                        r_out_valid   <= 1'b1;
                        r_out_product <= '0;
                    end
                end
                ST_DONE: begin
                    if (Out_Ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_multi_en  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule : multi_op_sequencer
`default_nettype wire

// File: tb/tb_multi_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_op_sequencer
// Description : Self-checking bench: Booth core model, queue-based reference
//               model and directed plus randomized stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        In_Valid;
    logic        In_Ready;
    logic [7:0]  In_Multiplicand;
    logic [7:0]  In_Multiplier;
    logic        Multi_En;
    logic [7:0]  Multiplicand;
    logic [7:0]  Multiplier;
    logic        Multip_Finsh;
    logic [15:0] Multiplication_Out;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [15:0] Out_Product;
    logic        Out_Error;

    multi_op_sequencer #(
        .Data_Width     (8),
        .Fifo_Depth     (2),
        .Timeout_Cycles (16)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .In_Valid           (In_Valid),
        .In_Ready           (In_Ready),
        .In_Multiplicand    (In_Multiplicand),
        .In_Multiplier      (In_Multiplier),
        .Multi_En           (Multi_En),
        .Multiplicand       (Multiplicand),
        .Multiplier         (Multiplier),
        .Multip_Finsh       (Multip_Finsh),
        .Multiplication_Out (Multiplication_Out),
        .Out_Valid          (Out_Valid),
        .Out_Ready          (Out_Ready),
        .Out_Product        (Out_Product),
        .Out_Error          (Out_Error)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mul16(input logic [7:0] a, input logic [7:0] b);
        int ia;
        int ib;
        ia = $signed(a);
        ib = $signed(b);
        return 16'(ia * ib);
    endfunction

    // Core model: finishes 9 cycles after Multi_En rises unless stalled.
    bit core_stall = 1'b0;
    bit force_fin  = 1'b0;
    int core_cnt   = 0;

    always @(posedge clk) begin
        if (!Multi_En) core_cnt <= 0;
        else           core_cnt <= core_cnt + 1;
    end

    assign Multip_Finsh       = force_fin || (Multi_En && !core_stall && core_cnt == 9);
    assign Multiplication_Out = force_fin ? 16'h5A5A : mul16(Multiplicand, Multiplier);

    // Reference model: accepted pairs in order, retired at the output handshake.
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
    } pair_t;

    pair_t q[$];
    logic  p_en, p_fin, p_ov;
    logic [7:0] p_mc, p_mp;
    int    ov_count = 0;

    always @(negedge clk) begin
        pair_t h;
        #2;
        if (rst) begin
            q.delete();
            p_en = 1'b0; p_fin = 1'b0; p_ov = 1'b0; p_mc = '0; p_mp = '0;
        end else begin
            if (Out_Valid) ov_count++;
            if (Multi_En && !p_en) begin
                check("gap_before_start", p_ov, 1'b0);
                if (q.size() == 0) begin
                    check("start_without_pair", 1'b1, 1'b0);
                end else begin
                    check("operand_a", Multiplicand, q[0].a);
                    check("operand_b", Multiplier, q[0].b);
                end
            end
            if (Multi_En && p_en) begin
                check("operands_stable", {Multiplicand, Multiplier}, {p_mc, p_mp});
            end
            if (p_en && p_fin) begin
                check("valid_after_finish", Out_Valid, 1'b1);
                check("en_drop_after_finish", Multi_En, 1'b0);
            end
            if (Out_Valid && Out_Ready) begin
                if (q.size() == 0) begin
                    check("result_without_pair", 1'b1, 1'b0);
                end else begin
                    h = q.pop_front();
                    check("product", Out_Product, core_stall ? 16'h0000 : mul16(h.a, h.b));
                    check("error", Out_Error, core_stall);
                end
            end
            if (In_Valid && In_Ready) begin
                h.a = In_Multiplicand;
                h.b = In_Multiplier;
                q.push_back(h);
            end
            p_en = Multi_En; p_fin = Multip_Finsh; p_ov = Out_Valid;
            p_mc = Multiplicand; p_mp = Multiplier;
        end
    end

    task automatic push(input logic [7:0] a, input logic [7:0] b);
        int n;
        In_Valid = 1'b1;
        In_Multiplicand = a;
        In_Multiplier = b;
        #1;
        n = 0;
        while (!In_Ready && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        check("push_accepted", In_Ready, 1'b1);
        @(negedge clk);
        In_Valid = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (Out_Valid) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic wait_en(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (Multi_En) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic drain(input string tag);
        Out_Ready = 1'b1;
        In_Valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !Out_Valid && !Multi_En) break;
        end
        check(tag, q.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int cnt;
        pair_t pairs[4];

        rst = 1'b1; In_Valid = 1'b0; In_Multiplicand = '0; In_Multiplier = '0; Out_Ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", In_Ready, 1'b1);
        check("rst_multi_en", Multi_En, 1'b0);
        check("rst_operands", {Multiplicand, Multiplier}, 16'h0000);
        check("rst_out_valid", Out_Valid, 1'b0);
        check("rst_out_product", Out_Product, 16'h0000);
        check("rst_out_error", Out_Error, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 3 * -2 with start latency
        Out_Ready = 1'b1;
        In_Valid = 1'b1; In_Multiplicand = 8'd3; In_Multiplier = 8'hFE;
        @(negedge clk);
        In_Valid = 1'b0;
        #1;
        check("en_low_n1", Multi_En, 1'b0);
        @(negedge clk); #1;
        check("en_high_n2", Multi_En, 1'b1);
        wait_valid(100, ok);
        check("wait_valid_3x-2", ok, 1'b1);
        check("prod_3x-2", Out_Product, 16'hFFFA);
        check("err_3x-2", Out_Error, 1'b0);
        drain("drain_3x-2");

        // -128 * -128
        push(8'h80, 8'h80);
        @(negedge clk); #1;
        wait_valid(100, ok);
        check("wait_valid_min", ok, 1'b1);
        check("prod_min", Out_Product, 16'h4000);
        drain("drain_min");

        // Four back-to-back pairs with output stalled
        Out_Ready = 1'b0;
        pairs[0] = '{8'd11, 8'd5};
        pairs[1] = '{8'hF3, 8'd7};
        pairs[2] = '{8'd100, 8'hC0};
        pairs[3] = '{8'h7F, 8'h7F};
        fork
            begin
                for (int k = 0; k < 4; k++) push(pairs[k].a, pairs[k].b);
            end
            begin
                @(negedge clk); #1;
                wait_valid(100, ok);
                check("wait_valid_burst", ok, 1'b1);
                repeat (2) @(negedge clk);
                #1;
                check("burst_full", In_Ready, 1'b0);
                check("burst_q_depth", q.size(), 3);
                repeat (5) @(negedge clk);
                #1;
                check("burst_still_full", In_Ready, 1'b0);
                check("burst_hold_valid", Out_Valid, 1'b1);
                check("burst_hold_prod", Out_Product, 16'h0037);
                Out_Ready = 1'b1;
            end
        join
        drain("drain_burst");

        // Spurious finish while idle and while holding a result
        @(negedge clk);
        force_fin = 1'b1;
        @(negedge clk);
        force_fin = 1'b0;
        #1;
        check("spur_idle_valid", Out_Valid, 1'b0);
        check("spur_idle_en", Multi_En, 1'b0);
        Out_Ready = 1'b0;
        push(8'd5, 8'd7);
        @(negedge clk); #1;
        wait_valid(100, ok);
        check("wait_valid_spur", ok, 1'b1);
        @(negedge clk);
        force_fin = 1'b1;
        @(negedge clk);
        force_fin = 1'b0;
        #1;
        check("spur_done_prod", Out_Product, 16'h0023);
        check("spur_done_valid", Out_Valid, 1'b1);
        drain("drain_spur");

        // Core never finishes
        core_stall = 1'b1;
        Out_Ready = 1'b1;
        push(8'd9, 8'd9);
        #1;
        wait_en(10, ok);
        check("stall_started", ok, 1'b1);
`ifdef MULTI_SEQ_TIMEOUT_EN
        cnt = 0;
        while (!Out_Valid && cnt < 100) begin
            @(negedge clk); #1;
            cnt++;
        end
        check("timeout_latency", cnt, 16);
        check("timeout_prod", Out_Product, 16'h0000);
        check("timeout_err", Out_Error, 1'b1);
        drain("drain_timeout");
        core_stall = 1'b0;
`else
        cnt = 0;
        repeat (1000) @(negedge clk);
        #1;
        check("no_watchdog_en", Multi_En, 1'b1);
        check("no_watchdog_valid", Out_Valid, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        core_stall = 1'b0;
`endif

        // Reset three cycles into RUN with a second pair buffered
        @(negedge clk);
        Out_Ready = 1'b1;
        push(8'd1, 8'd2);
        push(8'd3, 8'd4);
        #1;
        wait_en(10, ok);
        check("rst_run_started", ok, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        check("midrun_rst_en", Multi_En, 1'b0);
        check("midrun_rst_ready", In_Ready, 1'b1);
        check("midrun_rst_valid", Out_Valid, 1'b0);
        rst = 1'b0;
        ov_count = 0;
        repeat (30) @(negedge clk);
        check("no_stale_result", ov_count, 0);
        check("no_stale_en", Multi_En, 1'b0);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            In_Valid = ($urandom_range(0, 1) == 1);
            In_Multiplicand = 8'($urandom);
            In_Multiplier = 8'($urandom);
            Out_Ready = ($urandom_range(0, 9) < 7);
        end
        drain("drain_random");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_multi_op_sequencer
`default_nettype wire

// File: doc/multi_op_sequencer.md
MULTI_OP_SEQUENCER -- requirements
Module: multi_op_sequencer

Interface
REQ-001 SHALL have parameter Data_Width, default 8, operand width (product 2*Data_Width).
REQ-002 SHALL have parameter Fifo_Depth, default 2, operand-pair buffer entries (power of two, >=2).
REQ-003 SHALL have parameter Timeout_Cycles, default 64, watchdog limit in RUN cycles.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 In_Valid  in  1  operand pair offered.
REQ-007 In_Ready  out  1  buffer not full.
REQ-008 In_Multiplicand / In_Multiplier  in  Data_Width each  signed operands.
REQ-009 Multi_En  out  1  start/hold request to the Booth core.
REQ-010 Multiplicand / Multiplier  out  Data_Width each  operands to the core.
REQ-011 Multip_Finsh  in  1  core completion flag.
REQ-012 Multiplication_Out  in  2*Data_Width  core signed product.
REQ-013 Out_Valid  out  1; Out_Ready  in  1  result handshake.
REQ-014 Out_Product  out  2*Data_Width  captured signed product.
REQ-015 Out_Error  out  1  result produced by watchdog timeout.

Function
REQ-016 Push on In_Valid&&In_Ready; In_Ready = not full, no same-cycle pop bypass.
REQ-017 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-018 IDLE: FIFO non-empty -> RUN next cycle; else stay.
REQ-019 RUN: Multi_En=1 (registered); Multiplicand/Multiplier = FIFO head, stable for the whole RUN.
REQ-020 RUN with Multip_Finsh=1: capture Multiplication_Out into Out_Product, pop FIFO, -> DONE; Multi_En=0 next cycle.
REQ-021 DONE: Out_Valid=1, Out_Product/Out_Error held; Out_Ready=1 -> IDLE; else stay.
REQ-022 Multi_En SHALL be low for at least one cycle (IDLE) between consecutive operations.
REQ-023 Latency: push accepted cycle N -> Multi_En high at N+2 if FSM idle; Multip_Finsh at cycle F -> Out_Valid at F+1.
REQ-024 Multip_Finsh outside RUN SHALL be ignored.
REQ-025 Push during pop (RUN->DONE) SHALL both take effect; count unchanged.
REQ-026 FIFO pointers wrap modulo Fifo_Depth; count width $clog2(Fifo_Depth)+1.

Reset
REQ-027 rst=1: FSM IDLE, FIFO empty, In_Ready=1, Multi_En=0, Multiplicand/Multiplier=0, Out_Valid=0, Out_Product=0, Out_Error=0, watchdog=0.
REQ-028 rst mid-RUN/DONE SHALL discard in-flight and buffered operations; outputs reach reset values the following cycle.

Configuration
REQ-029 Macro MULTI_SEQ_TIMEOUT_EN defined: watchdog counts RUN cycles from 0; on reaching Timeout_Cycles-1 without Multip_Finsh -> pop, Out_Product=0, Out_Error=1, -> DONE; counter clears on RUN entry.
REQ-030 Macro undefined: no watchdog logic, RUN waits indefinitely, Out_Error tied 0.

Structure
REQ-031 Shared package SHALL hold FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and default parameter constants.
REQ-032 Sub-module multi_op_fifo SHALL implement the operand buffer (push/pop/full/empty, 2*Data_Width data); FSM and watchdog in the top.

Verification (Data_Width=8, Fifo_Depth=2, core model finishes 9 cycles after Multi_En rise)
REQ-033 Push (3,-2), Out_Ready=1 -> Multi_En high 2 cycles after push, Out_Product=16'hFFFA, Out_Error=0.
REQ-034 Push (-128,-128) -> Out_Product=16'h4000.
REQ-035 Push 4 pairs back-to-back, Out_Ready=0 -> after first capture FIFO holds pairs 2,3, In_Ready=0, pair 4 stalled; release Out_Ready -> results in push order.
REQ-036 Multip_Finsh pulsed while IDLE/DONE -> no state change, no capture.
REQ-037 With MULTI_SEQ_TIMEOUT_EN, Timeout_Cycles=16, core never finishes -> Out_Valid 16 cycles after RUN entry, Out_Product=0, Out_Error=1; without macro, still in RUN after 1000 cycles.
REQ-038 rst asserted 3 cycles into RUN with 1 pair buffered -> next cycle Multi_En=0, In_Ready=1, Out_Valid=0, no stale result afterwards.
